// File: rtl/ctrl_pkg.sv
// Shared encodings for the execution-stage hazard/flush controller.
// The state encoding is visible on the State port, so the values are fixed.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_hazard_ctrl_raw_match.sv
// One source register compared against the X/M/W destinations.
// Register zero is hard-wired, so it can never be a RAW dependency.
module raw_match
    import ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] rd_x_i,
    input  logic       wr_x_i,
    input  logic [4:0] rd_m_i,
    input  logic       wr_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       wr_w_i,
    output logic       hit_o
);

    logic hit_x, hit_m, hit_w;

    assign hit_x = wr_x_i && (src_i == rd_x_i);
    assign hit_m = wr_m_i && (src_i == rd_m_i);
    assign hit_w = wr_w_i && (src_i == rd_w_i);

    assign hit_o = (src_i != REG_ZERO) && (hit_x || hit_m || hit_w);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execution-stage sequencing: stalls decode on RAW hazards (no forwarding)
// and runs a fixed-length flush after a taken branch.
module ex_hazard_ctrl
    import ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FD_Valid,
    input  logic [4:0]       FD_RS,
    input  logic [4:0]       FD_RT,
    input  logic             FD_UsesRT,
    input  logic [4:0]       DX_RD,
    input  logic             DX_RegWrite,
    input  logic [4:0]       XM_RD,
    input  logic             XM_RegWrite,
    input  logic [4:0]       MW_RD,
    input  logic             MW_RegWrite,
    input  logic             XF_Branch,
    output logic             Stall,
    output logic             Bubble,
    output logic             Flush,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // The branch cycle itself is the first flush cycle, hence the -2.
    localparam logic [2:0] RELOAD = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    state_t           state_q;
    logic [2:0]       fcnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic rs_hit, rt_hit, hazard;

    raw_match u_rs_match (
        .src_i  (FD_RS),
        .rd_x_i (DX_RD),
        .wr_x_i (DX_RegWrite),
        .rd_m_i (XM_RD),
        .wr_m_i (XM_RegWrite),
        .rd_w_i (MW_RD),
        .wr_w_i (MW_RegWrite),
        .hit_o  (rs_hit)
    );

    raw_match u_rt_match (
        .src_i  (FD_RT),
        .rd_x_i (DX_RD),
        .wr_x_i (DX_RegWrite),
        .rd_m_i (XM_RD),
        .wr_m_i (XM_RegWrite),
        .rd_w_i (MW_RD),
        .wr_w_i (MW_RegWrite),
        .hit_o  (rt_hit)
    );

    assign hazard = FD_Valid && (rs_hit || (FD_UsesRT && rt_hit));

    always_comb begin
        Stall  = 1'b0;
        Bubble = 1'b0;
        Flush  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A taken branch makes the stalled decode instruction wrong-path.
                if (XF_Branch) begin
                    Flush  = 1'b1;
                    Bubble = 1'b1;
                end else if (hazard) begin
                    Stall  = 1'b1;
                    Bubble = 1'b1;
                end
            end
            ST_FLUSH: begin
                Flush  = 1'b1;
                Bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (XF_Branch) begin
                        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_q <= ST_FLUSH;
                            fcnt_q  <= RELOAD;
                        end
                    end else if (hazard) begin
                        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (XF_Branch) begin
                        fcnt_q <= RELOAD;
                        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
                    end else if (fcnt_q == 3'd0) begin
                        state_q <= ST_RUN;
                    end else begin
                        fcnt_q <= fcnt_q - 3'd1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign State    = state_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: reset, RAW stalls, branch flushes,
// counter saturation and reset during a flush.
module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        FD_Valid;
    logic [4:0]  FD_RS, FD_RT;
    logic        FD_UsesRT;
    logic [4:0]  DX_RD, XM_RD, MW_RD;
    logic        DX_RegWrite, XM_RegWrite, MW_RegWrite;
    logic        XF_Branch;
    logic        Stall, Bubble, Flush;
    logic [1:0]  State;
    logic [15:0] StallCnt, FlushCnt;

    int n_cmp = 0;
    int n_err = 0;

    ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .FD_Valid    (FD_Valid),
        .FD_RS       (FD_RS),
        .FD_RT       (FD_RT),
        .FD_UsesRT   (FD_UsesRT),
        .DX_RD       (DX_RD),
        .DX_RegWrite (DX_RegWrite),
        .XM_RD       (XM_RD),
        .XM_RegWrite (XM_RegWrite),
        .MW_RD       (MW_RD),
        .MW_RegWrite (MW_RegWrite),
        .XF_Branch   (XF_Branch),
        .Stall       (Stall),
        .Bubble      (Bubble),
        .Flush       (Flush),
        .State       (State),
        .StallCnt    (StallCnt),
        .FlushCnt    (FlushCnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        FD_Valid = 0; FD_RS = 0; FD_RT = 0; FD_UsesRT = 0;
        DX_RD = 0; DX_RegWrite = 0; XM_RD = 0; XM_RegWrite = 0;
        MW_RD = 0; MW_RegWrite = 0; XF_Branch = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        XF_Branch = 1; FD_Valid = 1; FD_RS = 5'd8; DX_RD = 5'd8; DX_RegWrite = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_cmp++;
            if (State !== 2'd0 || {Stall, Bubble, Flush} !== 3'b000 ||
                StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: state=%0d sbf=%b sc=%0d fc=%0d, want 0 000 0 0",
                         i, State, {Stall, Bubble, Flush}, StallCnt, FlushCnt);
            end
        end
        rst = 1;
        #1;
        n_cmp++;
        if (State !== 2'd0 || {Stall, Bubble, Flush} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_init_cycle: state=%0d sbf=%b, want 0 000", State, {Stall, Bubble, Flush});
        end
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (State !== 2'd1 || StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_to_run: state=%0d sc=%0d fc=%0d, want 1 0 0", State, StallCnt, FlushCnt);
        end
    endtask

    task automatic test_raw_stall();
        FD_Valid = 1; FD_RS = 5'd8; DX_RD = 5'd8; DX_RegWrite = 1;
        #1;
        n_cmp++;
        if ({Stall, Bubble, Flush} !== 3'b110) begin
            n_err++;
            $display("FAIL raw_x: sbf=%b, want 110", {Stall, Bubble, Flush});
        end
        tick();
        DX_RD = 0; DX_RegWrite = 0; XM_RD = 5'd8; XM_RegWrite = 1;
        #1;
        n_cmp++;
        if ({Stall, Bubble, Flush} !== 3'b110) begin
            n_err++;
            $display("FAIL raw_m: sbf=%b, want 110", {Stall, Bubble, Flush});
        end
        tick();
        XM_RD = 0; XM_RegWrite = 0; MW_RD = 5'd8; MW_RegWrite = 1;
        #1;
        n_cmp++;
        if ({Stall, Bubble, Flush} !== 3'b110) begin
            n_err++;
            $display("FAIL raw_w: sbf=%b, want 110", {Stall, Bubble, Flush});
        end
        tick();
        MW_RD = 0; MW_RegWrite = 0;
        #1;
        n_cmp++;
        if ({Stall, Bubble, Flush} !== 3'b000 || StallCnt !== 16'd3) begin
            n_err++;
            $display("FAIL raw_release: sbf=%b sc=%0d, want 000 3", {Stall, Bubble, Flush}, StallCnt);
        end
        clear_inputs();
    endtask

    task automatic test_no_hazard();
        FD_Valid = 1; FD_RS = 5'd0; DX_RD = 5'd0; DX_RegWrite = 1;
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin
            n_err++;
            $display("FAIL reg_zero: stall=%b, want 0", Stall);
        end
        FD_RS = 5'd3; FD_RT = 5'd9; FD_UsesRT = 0; DX_RD = 5'd9;
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin
            n_err++;
            $display("FAIL rt_unused: stall=%b, want 0", Stall);
        end
        FD_UsesRT = 1; FD_Valid = 0;
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin
            n_err++;
            $display("FAIL fd_invalid: stall=%b, want 0", Stall);
        end
        FD_Valid = 1; DX_RegWrite = 0; MW_RD = 5'd9; MW_RegWrite = 1;
        #1;
        n_cmp++;
        if (Stall !== 1'b1 || Bubble !== 1'b1) begin
            n_err++;
            $display("FAIL rt_hit_w: stall=%b bubble=%b, want 1 1", Stall, Bubble);
        end
        clear_inputs();
        tick();
        #1;
        n_cmp++;
        if (StallCnt !== 16'd3 || Stall !== 1'b0) begin
            n_err++;
            $display("FAIL no_hazard_cnt: sc=%0d stall=%b, want 3 0", StallCnt, Stall);
        end
    endtask

    task automatic test_branch();
        XF_Branch = 1;
        #1;
        n_cmp++;
        if (State !== 2'd1 || {Stall, Bubble, Flush} !== 3'b011) begin
            n_err++;
            $display("FAIL branch_c0: state=%0d sbf=%b, want 1 011", State, {Stall, Bubble, Flush});
        end
        tick();
        XF_Branch = 0;
        #1;
        n_cmp++;
        if (State !== 2'd2 || {Stall, Bubble, Flush} !== 3'b011) begin
            n_err++;
            $display("FAIL branch_c1: state=%0d sbf=%b, want 2 011", State, {Stall, Bubble, Flush});
        end
        tick();
        #1;
        n_cmp++;
        if (State !== 2'd1 || {Stall, Bubble, Flush} !== 3'b000 || FlushCnt !== 16'd1) begin
            n_err++;
            $display("FAIL branch_end: state=%0d sbf=%b fc=%0d, want 1 000 1",
                     State, {Stall, Bubble, Flush}, FlushCnt);
        end
    endtask

    task automatic test_back_to_back();
        FD_Valid = 1; FD_RS = 5'd5; XM_RD = 5'd5; XM_RegWrite = 1; XF_Branch = 1;
        #1;
        n_cmp++;
        if ({Stall, Bubble, Flush} !== 3'b011) begin
            n_err++;
            $display("FAIL branch_hazard: sbf=%b, want 011", {Stall, Bubble, Flush});
        end
        tick();
        #1;
        n_cmp++;
        if (State !== 2'd2 || Stall !== 1'b0 || Flush !== 1'b1) begin
            n_err++;
            $display("FAIL flush_rebranch: state=%0d stall=%b flush=%b, want 2 0 1", State, Stall, Flush);
        end
        tick();
        XF_Branch = 0;
        #1;
        n_cmp++;
        if (State !== 2'd2 || Flush !== 1'b1 || Stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_third: state=%0d flush=%b stall=%b, want 2 1 0", State, Flush, Stall);
        end
        clear_inputs();
        tick();
        #1;
        n_cmp++;
        if (State !== 2'd1 || Flush !== 1'b0 || FlushCnt !== 16'd3 || StallCnt !== 16'd3) begin
            n_err++;
            $display("FAIL flush_extend_end: state=%0d flush=%b fc=%0d sc=%0d, want 1 0 3 3",
                     State, Flush, FlushCnt, StallCnt);
        end
    endtask

    task automatic test_saturation();
        FD_Valid = 1; FD_RS = 5'd12; DX_RD = 5'd12; DX_RegWrite = 1;
        for (int i = 0; i < 65531; i++) tick();
        #1;
        n_cmp++;
        if (StallCnt !== 16'hFFFE) begin
            n_err++;
            $display("FAIL sat_preload: sc=%h, want fffe", StallCnt);
        end
        tick();
        #1;
        n_cmp++;
        if (StallCnt !== 16'hFFFF || Stall !== 1'b1) begin
            n_err++;
            $display("FAIL sat_reach: sc=%h stall=%b, want ffff 1", StallCnt, Stall);
        end
        tick();
        #1;
        n_cmp++;
        if (StallCnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_stick: sc=%h, want ffff", StallCnt);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_mid_flush_reset();
        XF_Branch = 1;
        tick();
        XF_Branch = 0;
        rst = 0;
        #1;
        n_cmp++;
        if (State !== 2'd2 || Flush !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_flush: state=%0d flush=%b, want 2 1", State, Flush);
        end
        tick();
        #1;
        n_cmp++;
        if (State !== 2'd0 || {Stall, Bubble, Flush} !== 3'b000 ||
            StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_flush_reset: state=%0d sbf=%b sc=%0d fc=%0d, want 0 000 0 0",
                     State, {Stall, Bubble, Flush}, StallCnt, FlushCnt);
        end
        rst = 1;
        tick();
        #1;
        n_cmp++;
        if (State !== 2'd1 || Flush !== 1'b0) begin
            n_err++;
            $display("FAIL recover_run: state=%0d flush=%b, want 1 0", State, Flush);
        end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_no_hazard();
        test_branch();
        test_back_to_back();
        test_saturation();
        test_mid_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
